opti_src: RTL and testbench
===========================

OPTI_SRC -- requirements
Module: opti_src

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, sample buffer depth (power of two).
REQ-002 SHALL have parameter ADDR_W, default 11, buffer address width (log2 DEPTH).
REQ-003 SHALL have parameter DATA_W, default 24, sample width in Q2.22.
REQ-004 SHALL have parameter DIV_W, default 8, pacing divider width.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have wr_en  in  1  host buffer write strobe.
REQ-007 SHALL have wr_addr  in  ADDR_W  host write address.
REQ-008 SHALL have wr_data  in  DATA_W  host write sample, signed Q2.22.
REQ-009 SHALL have go  in  1  single-cycle run request.
REQ-010 SHALL have len  in  ADDR_W+1  samples per pass, valid range 1..DEPTH.
REQ-011 SHALL have div  in  DIV_W  gap between samples, period = div+1 cycles.
REQ-012 SHALL have filter_done  in  1  completion pulse from the filter controller.
REQ-013 SHALL have start  out  1  single-cycle filter start pulse.
REQ-014 SHALL have data_in  out  DATA_W  signed Q2.22 sample to the filter.
REQ-015 SHALL have data_in_valid  out  1  sample qualifier.
REQ-016 SHALL have busy  out  1  high from the START state through WAIT.
REQ-017 SHALL have sent_cnt  out  ADDR_W+1  valid samples issued in the current run.
REQ-018 SHALL have done  out  1  single-cycle run-complete pulse.

Function
REQ-019 SHALL implement FSM states IDLE, START, STREAM, WAIT, FIN.
REQ-020 SHALL move IDLE->START on go=1 with len in 1..DEPTH; go with len=0 or len>DEPTH SHALL be ignored.
REQ-021 SHALL ignore go in every state other than IDLE.
REQ-022 SHALL latch len and div at go acceptance; later changes SHALL NOT affect the run.
REQ-023 SHALL assert start for exactly the START cycle (go sampled at edge k, start high in cycle k+1) and issue the buffer read of address 0.
REQ-024 SHALL assert the first data_in_valid in cycle k+2 and each further one exactly div+1 cycles after the previous; data_in_valid SHALL never be high for more than 1 cycle when div>0.
REQ-025 SHALL present buffer[n] on data_in with the n-th valid, and SHALL hold data_in stable between valids.
REQ-026 SHALL use a 1-cycle synchronous buffer read, prefetching the next address so pacing is unaffected at div=0.
REQ-027 SHALL increment sent_cnt on each valid and move STREAM->WAIT in the cycle after valid number len.
REQ-028 SHALL leave WAIT on filter_done=1 to FIN, pulse done in FIN, then return to IDLE; a filter_done seen in any other state SHALL be ignored.
REQ-029 SHALL accept host writes in every state; a write and a read to the same address in one cycle SHALL return the old data.
REQ-030 SHALL clear sent_cnt at go acceptance and hold it after the run.

Reset
REQ-031 SHALL on rst_n=0, immediately and at any point of a run, enter IDLE and drive start, data_in_valid, busy, done to 0 and data_in, sent_cnt to 0.
REQ-032 SHALL NOT clear buffer contents on reset; they are undefined after power-up.

Configuration
REQ-033 SHALL, with OPTI_SRC_LOOP_EN defined, add input port loop_en (1 bit); at the end of a pass with loop_en=1, addressing SHALL wrap to 0 with no gap beyond div and no new start pulse, and sent_cnt SHALL wrap to 0.
REQ-034 SHALL, with OPTI_SRC_LOOP_EN defined and loop_en sampled 0 at the last valid of a pass, end that pass normally into WAIT.
REQ-035 SHALL, without OPTI_SRC_LOOP_EN, have no loop_en port and always run a single pass.

Structure
REQ-036 SHALL take DATA_W, ADDR_W, DEPTH defaults and the FSM state encodings from the shared opti package.
REQ-037 SHALL put the buffer in sub-module opti_src_ram (1 write port, 1 synchronous read port).

Verification
REQ-038 SHALL check: write buffer[i]=i*4096, len=4, div=0, go -> start 1 cycle, then valids on 4 consecutive cycles carrying 0,4096,8192,12288, sent_cnt=4.
REQ-039 SHALL check: len=3, div=2 -> valids exactly 3 cycles apart; filter_done 10 cycles later -> done 1 cycle, busy falls.
REQ-040 SHALL check: go during STREAM and go with len=0 -> no effect on sequence; no start pulse.
REQ-041 SHALL check: rst_n low mid-STREAM after 2 valids -> all outputs 0 at once; new go restarts at address 0.
REQ-042 SHALL check: len=2048, div=0 -> 2048 back-to-back valids, last carries buffer[2047], sent_cnt=2048.
REQ-043 SHALL check, with OPTI_SRC_LOOP_EN: len=2, loop_en=1 for 3 passes then 0 -> samples 0,1,0,1,0,1 with no extra start; WAIT then entered.

Source files
------------

// File: rtl/opti_pkg.sv
// opti_pkg: shared widths, buffer depth and source FSM encoding for the opti datapath.
package opti_pkg;
    localparam int OPTI_DEPTH  = 2048;
    localparam int OPTI_ADDR_W = 11;
    localparam int OPTI_DATA_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_FIN
    } src_state_t;
endpackage

// File: rtl/opti_src_ram.sv
// opti_src_ram: sample buffer, one write port and one registered read port (read-before-write).
module opti_src_ram
    import opti_pkg::*;
#(
    parameter int DEPTH  = OPTI_DEPTH,
    parameter int ADDR_W = OPTI_ADDR_W,
    parameter int DATA_W = OPTI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    // Contents are never reset; only the output register is, so data_in reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/opti_src.sv
// opti_src: paced sample source streaming a host-written buffer into the filter.
// Build option OPTI_SRC_LOOP_EN adds loop_en for continuous wrap-around passes.
module opti_src
    import opti_pkg::*;
#(
    parameter int DEPTH  = OPTI_DEPTH,
    parameter int ADDR_W = OPTI_ADDR_W,
    parameter int DATA_W = OPTI_DATA_W,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef OPTI_SRC_LOOP_EN
    input  logic              loop_en,
`endif
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              go,
    input  logic [ADDR_W:0]   len,
    input  logic [DIV_W-1:0]  div,
    input  logic              filter_done,
    output logic              start,
    output logic [DATA_W-1:0] data_in,
    output logic              data_in_valid,
    output logic              busy,
    output logic [ADDR_W:0]   sent_cnt,
    output logic              done
);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    src_state_t        state;
    logic [ADDR_W:0]   len_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  gap;
    logic [ADDR_W:0]   cnt_base;
    logic              loop_on, last, wrap, valid_nxt, go_ok;

`ifdef OPTI_SRC_LOOP_EN
    assign loop_on = loop_en;
`else
    assign loop_on = 1'b0;
`endif

    assign go_ok     = state == S_IDLE && go && len != '0 && len <= MAX_LEN;
    assign last      = state == S_STREAM && data_in_valid && sent_cnt == len_q;
    assign wrap      = last && loop_on;
    // sent_cnt doubles as the read address: each read is issued the cycle before its valid.
    assign cnt_base  = wrap ? '0 : sent_cnt;
    assign valid_nxt = state == S_START || (state == S_STREAM && gap == '0 && cnt_base < len_q);

    opti_src_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (valid_nxt),
        .rd_addr (cnt_base[ADDR_W-1:0]),
        .rd_data (data_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            start         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_in_valid <= 1'b0;
            sent_cnt      <= '0;
            len_q         <= '0;
            div_q         <= '0;
            gap           <= '0;
        end else begin
            start         <= 1'b0;
            done          <= 1'b0;
            data_in_valid <= valid_nxt;
            sent_cnt      <= cnt_base + (ADDR_W+1)'(valid_nxt);
            gap           <= valid_nxt ? div_q : (gap != '0 ? gap - 1'b1 : gap);
            case (state)
                S_IDLE: if (go_ok) begin
                    state    <= S_START;
                    start    <= 1'b1;
                    busy     <= 1'b1;
                    len_q    <= len;
                    div_q    <= div;
                    sent_cnt <= '0;
                end
                S_START:  state <= S_STREAM;
                S_STREAM: if (last && !loop_on) state <= S_WAIT;
                S_WAIT: if (filter_done) begin
                    state <= S_FIN;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                S_FIN:    state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_opti_src.sv
// tb_opti_src: randomized scoreboard bench; valid timing, sample values and counts come from a cycle-level reference model.
module tb_opti_src;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        go = 1'b0;
    logic [11:0] len = '0;
    logic [7:0]  div = '0;
    logic        filter_done = 1'b0;
    logic        start, data_in_valid, busy, done;
    logic [23:0] data_in;
    logic [11:0] sent_cnt;

    opti_src dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef OPTI_SRC_LOOP_EN
        .loop_en       (loop_en),
`endif
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .go            (go),
        .len           (len),
        .div           (div),
        .filter_done   (filter_done),
        .start         (start),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .busy          (busy),
        .sent_cnt      (sent_cnt),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [23:0] d;
        int          n;
    } exp_t;

    exp_t        q[$];
    int          sq[$];
    logic [23:0] ref_mem [2048];
    logic [23:0] last_d;
    bit          have_last = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (!rst_n) begin
            have_last = 0;
            return;
        end
        if (start) begin
            if (sq.size() == 0) chk("start_unexpected", 64'(1), 64'(0));
            else chk("start_cycle", 64'(cyc), 64'(sq.pop_front()));
        end
        if (data_in_valid) begin
            if (q.size() == 0) chk("valid_unexpected", 64'(1), 64'(0));
            else begin
                e = q.pop_front();
                chk("valid_cycle", 64'(cyc), 64'(e.c));
                chk("valid_data", 64'(data_in), 64'(e.d));
                chk("valid_cnt", 64'(sent_cnt), 64'(e.n));
            end
            last_d    = data_in;
            have_last = 1;
        end else if (have_last) chk("data_hold", 64'(data_in), 64'(last_d));
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int v);
        wr_en   = 1'b1;
        wr_addr = 11'(a);
        wr_data = 24'(v);
        ref_mem[a] = 24'(v);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_start"}, 64'(start), 64'(0));
        chk({nm, "_valid"}, 64'(data_in_valid), 64'(0));
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_done"}, 64'(done), 64'(0));
        chk({nm, "_data"}, 64'(data_in), 64'(0));
        chk({nm, "_cnt"}, 64'(sent_cnt), 64'(0));
    endtask

    // One run: go, expected valids per pass, optional extra go / write collision, then the filter handshake.
    task automatic run(input int l, input int d, input int passes, input int fd, input bit collide, input bit inj);
        int g;
        @(posedge clk);
        #1;
        g       = cyc;
        go      = 1'b1;
        len     = 12'(l);
        div     = 8'(d);
        loop_en = passes > 1;
        sq.push_back(g + 1);
        for (int p = 0; p < passes; p++)
            for (int n = 0; n < l; n++)
                q.push_back('{g + 2 + (p * l + n) * (d + 1), ref_mem[n], n + 1});
        @(posedge clk);
        #1;
        go  = 1'b0;
        len = 12'($urandom);
        div = 8'($urandom);
        chk("run_start", 64'(start), 64'(1));
        chk("run_busy", 64'(busy), 64'(1));
        chk("run_cnt_clear", 64'(sent_cnt), 64'(0));
        if (collide) wr(0, int'($urandom_range(0, 24'hffffff)));
        if (inj) begin
            to_cyc(g + 4);
            go  = 1'b1;
            len = 12'(2);
            div = 8'(0);
            @(posedge clk);
            #1;
            go = 1'b0;
        end
        if (passes > 1) begin
            to_cyc(g + 2 + ((passes - 1) * l - 1) * (d + 1) + 1);
            loop_en = 1'b0;
        end
        to_cyc(g + 2 + (passes * l - 1) * (d + 1) + 1);
        chk("wait_busy", 64'(busy), 64'(1));
        chk("wait_cnt", 64'(sent_cnt), 64'(l));
        repeat (fd) begin
            @(posedge clk);
            #1;
        end
        chk("wait_no_done", 64'(done), 64'(0));
        filter_done = 1'b1;
        @(posedge clk);
        #1;
        filter_done = 1'b0;
        chk("fin_done", 64'(done), 64'(1));
        chk("fin_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_cnt_hold", 64'(sent_cnt), 64'(l));
        chk("sb_drained", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 2048; i++) wr(i, i * 4096);

        run(4, 0, 1, 3, 0, 0);
        run(3, 2, 1, 10, 0, 0);

        // Ignored requests in IDLE: zero length, oversize length, stray filter_done.
        go  = 1'b1;
        len = 12'(0);
        @(posedge clk);
        #1;
        len = 12'(2049);
        @(posedge clk);
        #1;
        go          = 1'b0;
        filter_done = 1'b1;
        @(posedge clk);
        #1;
        filter_done = 1'b0;
        chk("ignored_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        chk("ignored_done", 64'(done), 64'(0));
        chk("ignored_busy2", 64'(busy), 64'(0));

        run(5, 1, 1, 2, 0, 1);
        run(4, 0, 1, 1, 1, 0);

        // Asynchronous reset in the middle of a stream.
        @(posedge clk);
        #1;
        g   = cyc;
        go  = 1'b1;
        len = 12'(6);
        div = 8'(1);
        sq.push_back(g + 1);
        for (int n = 0; n < 2; n++) q.push_back('{g + 2 + n * 2, ref_mem[n], n + 1});
        @(posedge clk);
        #1;
        go = 1'b0;
        to_cyc(g + 5);
        chk("pre_reset_busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("sb_after_reset", 64'(q.size()), 64'(0));
        run(3, 0, 1, 2, 0, 0);

        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(1, 4)) wr(int'($urandom_range(0, 63)), int'($urandom_range(0, 24'hffffff)));
            run(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 0);
        end

        for (int i = 2040; i < 2048; i++) wr(i, int'($urandom_range(0, 24'hffffff)));
        run(2048, 0, 1, 2, 0, 0);

`ifdef OPTI_SRC_LOOP_EN
        for (int i = 0; i < 4; i++) wr(i, i);
        run(2, 0, 3, 3, 0, 0);
        run(3, 1, 2, 1, 0, 0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
